// File: rtl/goose_motion_ctrl_pkg.sv
// goose_pkg: state codes, screen geometry and timing constants for the goose motion controller
package goose_pkg;
  typedef logic [1:0] state_t;
  localparam state_t WALK_R = 2'd0;
  localparam state_t WALK_L = 2'd1;
  localparam state_t TURN   = 2'd2;
  localparam state_t HONK   = 2'd3;
  localparam int SCREEN_W = 640;
  localparam int SPRITE_W = 32;
  localparam int X_MAX = SCREEN_W - SPRITE_W;
  localparam int X_MIN = 0;
  localparam int START_X = 100;
  localparam int START_Y = 80;
  localparam int STEP = 2;
  localparam int FRAMES_PER_ANIM = 8;
  localparam int TURN_FRAMES = 16;
  localparam int HONK_FRAMES = 30;
  localparam int CNT_W = 5;
  localparam int ANIM_W = $clog2(FRAMES_PER_ANIM);
  localparam logic [1:0] HONK_POSE = 2'd3;
endpackage

// File: rtl/goose_frame_timer.sv
// goose_frame_timer: loadable frame down-counter shared by the TURN and HONK episodes
module goose_frame_timer
  import goose_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - CNT_W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/goose_motion_ctrl.sv
// goose_motion_ctrl: frame-synchronous walk/turn/honk controller; GOOSE_BOB_EN adds a walk bob on goose_y
module goose_motion_ctrl
  import goose_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       pause,
  input  logic       honk_req,
  output logic [9:0] goose_x,
  output logic [9:0] goose_y,
  output logic [1:0] anim_frame,
  output logic       facing_left,
  output logic       honk_active
);
  state_t state;
  logic honk_pending, pend, active, walk, to_turn, to_honk, t_zero;
  logic [ANIM_W-1:0] div;
  logic [10:0] x_up;
  assign active = frame_start && !pause;
  assign walk = state == WALK_R || state == WALK_L;
  // a request in the same cycle as the frame pulse already counts for that frame
  assign pend = honk_pending || honk_req;
  assign x_up = {1'b0, goose_x} + 11'(STEP);
  assign to_honk = walk && pend;
  assign to_turn = !pend && (state == WALK_R ? x_up >= 11'(X_MAX)
                                             : state == WALK_L && {1'b0, goose_x} <= 11'(X_MIN + STEP));
  goose_frame_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (active && (to_honk || to_turn)),
    .en      (active && !walk),
    .load_val(to_honk ? CNT_W'(HONK_FRAMES - 1) : CNT_W'(TURN_FRAMES - 1)),
    .zero    (t_zero)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state        <= WALK_R;
      goose_x      <= 10'(START_X);
      anim_frame   <= 2'd0;
      facing_left  <= 1'b0;
      honk_active  <= 1'b0;
      honk_pending <= 1'b0;
      div          <= '0;
    end else begin
      if (honk_req && state != HONK) honk_pending <= 1'b1;
      if (active) begin
        if (to_honk) begin
          state        <= HONK;
          honk_pending <= 1'b0;
          anim_frame   <= HONK_POSE;
          honk_active  <= 1'b1;
        end else if (to_turn) begin
          state      <= TURN;
          goose_x    <= state == WALK_R ? 10'(X_MAX) : 10'(X_MIN);
          anim_frame <= 2'd0;
        end else if (walk) begin
          goose_x <= state == WALK_R ? x_up[9:0] : goose_x - 10'(STEP);
          div     <= div == ANIM_W'(FRAMES_PER_ANIM - 1) ? '0 : div + ANIM_W'(1);
          if (div == ANIM_W'(FRAMES_PER_ANIM - 1)) anim_frame <= anim_frame == 2'd2 ? 2'd0 : anim_frame + 2'd1;
        end else if (t_zero) begin
          honk_active <= 1'b0;
          anim_frame  <= 2'd0;
          div         <= '0;
          if (state == TURN) facing_left <= !facing_left;
          state <= (state == TURN) != facing_left ? WALK_L : WALK_R;
        end
      end
    end
`ifdef GOOSE_BOB_EN
  assign goose_y = walk && anim_frame == 2'd1 ? 10'(START_Y - 2) : 10'(START_Y);
`else
  assign goose_y = 10'(START_Y);
`endif
endmodule

// File: tb/tb_goose_motion_ctrl.sv
// tb_goose_motion_ctrl: directed vector table plus hand sequences for honk drop and mid-episode reset
module tb_goose_motion_ctrl;
  logic clk = 1'b0, rst = 1'b1, frame_start = 1'b0, pause = 1'b0, honk_req = 1'b0;
  logic [9:0] goose_x, goose_y;
  logic [1:0] anim_frame;
  logic facing_left, honk_active;
  int checks = 0, errors = 0;

  typedef struct {
    int n; bit p; bit h;
    int x; int a; bit f; bit ha;
  } vec_t;
  vec_t vec [16];

  goose_motion_ctrl dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pause(pause), .honk_req(honk_req),
    .goose_x(goose_x), .goose_y(goose_y), .anim_frame(anim_frame),
    .facing_left(facing_left), .honk_active(honk_active)
  );

  always #5 clk = ~clk;

  function automatic int exp_y(int a);
`ifdef GOOSE_BOB_EN
    return a == 1 ? 78 : 80;
`else
    return 80;
`endif
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, int x, int a, bit f, bit ha);
    chk({tag, " x"}, goose_x, x);
    chk({tag, " y"}, goose_y, exp_y(a));
    chk({tag, " anim"}, anim_frame, a);
    chk({tag, " facing"}, facing_left, f);
    chk({tag, " honk"}, honk_active, ha);
  endtask

  task automatic frames(int n, bit p, bit h);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      pause = p;
      honk_req = h && i == 0;
      @(posedge clk); #1;
    end
    frame_start = 1'b0;
    honk_req = 1'b0;
    pause = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    vec[0]  = '{7,   0, 0, 114, 0, 0, 0};
    vec[1]  = '{1,   0, 0, 116, 1, 0, 0};
    vec[2]  = '{2,   0, 0, 120, 1, 0, 0};
    vec[3]  = '{243, 0, 0, 606, 1, 0, 0};
    vec[4]  = '{1,   0, 0, 608, 0, 0, 0};
    vec[5]  = '{15,  0, 0, 608, 0, 0, 0};
    vec[6]  = '{1,   0, 0, 608, 0, 1, 0};
    vec[7]  = '{1,   0, 0, 606, 0, 1, 0};
    vec[8]  = '{1,   0, 1, 606, 3, 1, 1};
    vec[9]  = '{29,  0, 0, 606, 3, 1, 1};
    vec[10] = '{1,   0, 0, 606, 0, 1, 0};
    vec[11] = '{1,   0, 0, 604, 0, 1, 0};
    vec[12] = '{5,   1, 1, 604, 0, 1, 0};
    vec[13] = '{1,   0, 0, 604, 3, 1, 1};
    vec[14] = '{30,  0, 0, 604, 0, 1, 0};
    vec[15] = '{302, 0, 0, 0,   0, 1, 0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_all("reset", 100, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      frames(vec[i].n, vec[i].p, vec[i].h);
      chk_all($sformatf("v%0d", i), vec[i].x, vec[i].a, vec[i].f, vec[i].ha);
    end

    frames(15, 0, 0);
    chk_all("left turn hold", 0, 0, 1, 0);
    frames(1, 0, 0);
    chk_all("left turn done", 0, 0, 0, 0);
    frames(1, 0, 0);
    chk_all("walk right again", 2, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 chk_all("idle hold", 2, 0, 0, 0);

    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk_all("reset2", 100, 0, 0, 0);
    frames(1, 0, 1);
    chk_all("honk start", 100, 3, 0, 1);
    honk_req = 1'b1;
    @(posedge clk); #1 honk_req = 1'b0;
    frames(30, 0, 0);
    chk_all("honk end", 100, 0, 0, 0);
    frames(1, 0, 0);
    chk_all("no second honk", 102, 0, 0, 0);

    frames(1, 0, 1);
    chk_all("honk mid", 102, 3, 0, 1);
    honk_req = 1'b1;
    @(posedge clk); #1 honk_req = 1'b0;
    rst = 1'b1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    frame_start = 1'b0;
    chk_all("reset mid honk", 100, 0, 0, 0);
    frames(1, 0, 0);
    chk_all("pending lost", 102, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
